// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, addressing modes, instruction field positions and sequencer states.
package cpu_ctrl_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;
  localparam logic [1:0] MODE_IMM = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;
  localparam int OP_LSB = 28;
  localparam int MODE_LSB = 26;
  localparam int DST_LSB = 21;
  localparam int SRC_LSB = 16;
  localparam int LIT_W = 16;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXECUTE,
    S_WB,
    S_HALT
  } state_e;
  function automatic logic [31:0] sext_lit(input logic [LIT_W-1:0] lit);
    return {{(32-LIT_W){lit[LIT_W-1]}}, lit};
  endfunction
endpackage

// File: rtl/instr_decode.sv
// instr_decode: splits an instruction word into class flags and operand fields.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_nop,
  output logic        is_halt,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_direct,
  output logic [1:0]  mode,
  output logic [4:0]  src,
  output logic [4:0]  dst,
  output logic [31:0] lit
);
  logic [3:0] op;
  assign op = ir[OP_LSB+:4];
  assign mode = ir[MODE_LSB+:2];
  assign src = ir[SRC_LSB+:5];
  assign dst = ir[DST_LSB+:5];
  assign lit = sext_lit(ir[LIT_W-1:0]);
  assign is_nop = op == OP_NOP;
  assign is_halt = op == OP_HALT;
  assign is_store = op == OP_STORE;
  assign is_branch = op == OP_BRANCH;
  assign is_direct = mode == MODE_DIRECT;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control FSM owning the PC and the shared memory port.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [1:0]  mode,
  output logic [31:0] litsrc,
  output logic [4:0]  src,
  output logic [4:0]  dst,
  output logic        store,
  output logic        branch,
  output logic        operand_le,
  output logic        alu_en,
  output logic        gpr_we,
  output logic        halted
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, litsrc_q, litsrc_d;
  logic [1:0] mode_q, mode_d;
  logic [4:0] src_q, src_d, dst_q, dst_d;
  logic store_q, store_d, branch_q, branch_d;
  logic is_nop, is_halt, is_store, is_branch, is_direct;
  logic [1:0] dec_mode;
  logic [4:0] dec_src, dec_dst;
  logic [31:0] dec_lit;
  instr_decode u_dec (
    .ir(ir_q),
    .is_nop(is_nop),
    .is_halt(is_halt),
    .is_store(is_store),
    .is_branch(is_branch),
    .is_direct(is_direct),
    .mode(dec_mode),
    .src(dec_src),
    .dst(dec_dst),
    .lit(dec_lit)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    mode_d = mode_q;
    litsrc_d = litsrc_q;
    src_d = src_q;
    dst_d = dst_q;
    store_d = store_q;
    branch_d = branch_q;
    unique case (state_q)
      S_FETCH: begin
        ir_d = mem_ready ? mem_rdata : ir_q;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        mode_d = dec_mode;
        litsrc_d = dec_lit;
        src_d = dec_src;
        dst_d = dec_dst;
        store_d = is_store;
        branch_d = is_branch;
        state_d = is_halt ? S_HALT : is_nop ? S_WB : is_direct ? S_OPERAND : S_EXECUTE;
      end
      S_OPERAND: state_d = mem_ready ? S_EXECUTE : S_OPERAND;
      S_EXECUTE: state_d = S_WB;
      S_WB: begin
        // a store lingers here until its write completes; everything else leaves at once
        if (!store_q || mem_ready) begin
          pc_d = branch_q ? alu_result : pc_q + PC_STEP;
          store_d = 1'b0;
          branch_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      mode_q <= '0;
      litsrc_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      store_q <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      mode_q <= mode_d;
      litsrc_q <= litsrc_d;
      src_q <= src_d;
      dst_q <= dst_d;
      store_q <= store_d;
      branch_q <= branch_d;
    end
  end
  // reset state is FETCH, so the request is gated to drop the instant reset asserts
  assign mem_req = rst_n && (state_q == S_FETCH || state_q == S_OPERAND || (state_q == S_WB && store_q));
  assign mem_we = state_q == S_WB && store_q;
  assign mem_addr = state_q == S_FETCH ? pc_q : litsrc_q;
  assign operand_le = state_q == S_OPERAND && mem_ready;
  assign alu_en = state_q == S_EXECUTE;
  assign gpr_we = state_q == S_WB && !store_q && !branch_q && !is_nop;
  assign halted = state_q == S_HALT;
  assign pc = pc_q;
  assign ir = ir_q;
  assign mode = mode_q;
  assign litsrc = litsrc_q;
  assign src = src_q;
  assign dst = dst_q;
  assign store = store_q;
  assign branch = branch_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: trace-level scoreboard with randomized programs and memory waits.
module tb_instr_sequencer;
  logic clk = 0, rst_n = 0;
  logic mem_req, mem_we, mem_ready = 0;
  logic [31:0] mem_addr, mem_rdata = 0, alu_result = 0;
  logic [31:0] pc, ir, litsrc;
  logic [1:0] mode;
  logic [4:0] src, dst;
  logic store, branch, operand_le, alu_en, gpr_we, halted;
  localparam int K_MEM = 0, K_OPLE = 1, K_ALU = 2, K_GPR = 3;
  typedef struct {
    int kind;
    logic [31:0] addr;
    logic we;
    logic [31:0] ins;
    logic st;
    logic br;
  } ev_t;
  typedef struct {
    logic [31:0] data;
    logic [31:0] alu;
  } rd_t;
  ev_t exp_q[$];
  rd_t rd_q[$];
  logic [31:0] mpc;
  int wait_mode = 1;
  int wl = -1;
  int n_chk = 0, n_pass = 0;
  logic pend = 0, pend_we = 0;
  logic [31:0] pend_addr = 0;
  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .alu_result(alu_result), .pc(pc), .ir(ir),
    .mode(mode), .litsrc(litsrc), .src(src), .dst(dst), .store(store), .branch(branch),
    .operand_le(operand_le), .alu_en(alu_en), .gpr_we(gpr_we), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic push_ev(input int kind, input logic [31:0] addr, input logic we, input logic [31:0] ins,
                         input logic st, input logic br);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.we = we;
    e.ins = ins;
    e.st = st;
    e.br = br;
    exp_q.push_back(e);
  endtask
  // ISA-level model: what one instruction at the model PC does on the bus and strobes
  task automatic add_instr(input logic [31:0] ins, input logic [31:0] alu);
    logic [3:0] op;
    logic [31:0] lit;
    logic st, br;
    rd_t r;
    op = ins[31:28];
    lit = {{16{ins[15]}}, ins[15:0]};
    st = op == 4'hE;
    br = op == 4'hF;
    push_ev(K_MEM, mpc, 1'b0, ins, 1'b0, 1'b0);
    r.data = ins;
    r.alu = alu;
    rd_q.push_back(r);
    if (op == 4'hD) return;
    if (op == 4'h0) begin
      mpc = mpc + 1;
      return;
    end
    if (ins[27:26] == 2'b01) begin
      push_ev(K_MEM, lit, 1'b0, ins, st, br);
      r.data = $urandom;
      rd_q.push_back(r);
      push_ev(K_OPLE, 0, 1'b0, ins, st, br);
    end
    push_ev(K_ALU, 0, 1'b0, ins, st, br);
    if (st) begin
      push_ev(K_MEM, lit, 1'b1, ins, st, br);
      mpc = mpc + 1;
    end else if (br) mpc = alu;
    else begin
      push_ev(K_GPR, 0, 1'b0, ins, 1'b0, 1'b0);
      mpc = mpc + 1;
    end
  endtask
  task automatic obs(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    if (kind != e.kind) return;
    if (kind == K_MEM) begin
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_we", 32'(mem_we), 32'(e.we));
    end
    if (kind == K_ALU) begin
      chk("ir", ir, e.ins);
      chk("mode", 32'(mode), 32'(e.ins[27:26]));
      chk("src", 32'(src), 32'(e.ins[20:16]));
      chk("dst", 32'(dst), 32'(e.ins[25:21]));
      chk("litsrc", litsrc, {{16{e.ins[15]}}, e.ins[15:0]});
    end
    chk("store", 32'(store), 32'(e.st));
    chk("branch", 32'(branch), 32'(e.br));
  endtask
  // memory responder: serves reads in trace order with configurable waits
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      mem_ready = 0;
      wl = -1;
    end else if (mem_req) begin
      if (wl < 0) wl = wait_mode == 2 ? 2 : wait_mode == 1 ? 0 : $urandom_range(0, 2);
      if (wait_mode == 3) mem_ready = 0;
      else if (wl == 0) begin
        mem_ready = 1;
        if (!mem_we) begin
          if (rd_q.size() > 0) begin
            mem_rdata = rd_q[0].data;
            alu_result = rd_q[0].alu;
            void'(rd_q.pop_front());
          end else mem_rdata = 32'hD000_0000;
        end
        wl = -1;
      end else begin
        mem_ready = 0;
        wl--;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) pend = 0;
    else begin
      chk("strobe_excl", 32'($countones({operand_le, alu_en, gpr_we}) > 1), 0);
      if (pend) begin
        chk("req_hold", 32'(mem_req), 1);
        chk("addr_hold", mem_addr, pend_addr);
        chk("we_hold", 32'(mem_we), 32'(pend_we));
      end
      pend = mem_req && !mem_ready;
      pend_addr = mem_addr;
      pend_we = mem_we;
      if (mem_req && mem_ready) obs(K_MEM);
      if (operand_le) obs(K_OPLE);
      if (alu_en) obs(K_ALU);
      if (gpr_we) obs(K_GPR);
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 0);
    chk("rst_strobes", 32'({operand_le, alu_en, gpr_we, halted, store, branch, mem_we}), 0);
    chk("rst_fields", 32'({mode, src, dst}), 0);
    chk("rst_litsrc", litsrc, 0);
    mpc = 0;
    add_instr(32'h1000_0005, 0);
    wait_mode = 1;
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", mem_addr, 0);
      end
      if (c == 3) chk("alu_en_cycle3", 32'(alu_en), 1);
      if (c == 4) begin
        chk("gpr_we_cycle4", 32'(gpr_we), 1);
        wait_mode = 3;
      end
      if (c == 5) begin
        chk("pc_after_op", pc, 1);
        chk("litsrc_imm", litsrc, 5);
        chk("next_fetch_addr", mem_addr, 1);
      end
    end
    chk("stall_req", 32'(mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_pc", pc, 32'h0);
    chk("trace_a_done", exp_q.size(), 0);
    exp_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_state", 32'({ir != 0, halted, store, branch}), 0);
    mpc = 0;
    add_instr(32'h1400_0010, 0);
    add_instr(32'hE000_FFFF, 0);
    add_instr(32'hF800_0000, 32'h40);
    add_instr(32'hF000_0000, 32'hFFFF_FFFF);
    add_instr(32'h2000_0003, 0);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ins;
      int r;
      r = $urandom_range(0, 9);
      ins = {r == 0 ? 4'h0 : r == 1 ? 4'hE : r == 2 ? 4'hF : 4'($urandom_range(1, 12)), 28'($urandom)};
      add_instr(ins, $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
    end
    add_instr(32'hD000_0000, 0);
    wait_mode = 2;
    @(posedge clk);
    #1 rst_n = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pc == 0 && n <= 50);
    chk("direct_wait_cycles", n, 10);
    wait_mode = 0;
    for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
    chk("halted", 32'(halted), 1);
    chk("trace_b_done", exp_q.size(), 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(mem_req);
    end
    chk("halt_no_req", n, 0);
    chk("halt_held", 32'(halted), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
